arithm_seq: RTL and testbench

ARITHM_SEQ -- requirements
Module: arithm_seq

---
 rtl/arithm_seq.sv | 166 ++++++++++++++++
 tb/tb_arithm_seq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/arithm_seq.sv
// Small sequential arithmetic unit with a valid/ready handshake on both sides.
// Single-cycle ALU ops finish one cycle after accept. MUL/MULHU/DIVU/REMU
// run as radix-2 iterations over bitWidth cycles, sharing one 2*bitWidth
// accumulator.
module arithm_seq #(
  parameter int bitWidth = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                valid_i,
  input  logic [3:0]          op_i,
  input  logic [bitWidth-1:0] rs1_i,
  input  logic [bitWidth-1:0] rs2_i,
  output logic                ready_o,
  input  logic                flush_i,
  output logic                valid_o,
  output logic [bitWidth-1:0] result_o,
  input  logic                ready_i,
  output logic                busy_o
);

  localparam int SW = $clog2(bitWidth);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state_reg, state_next;

  logic                  accept;
  logic                  is_iter;
  logic                  last_step;
  logic [SW-1:0]         shamt;
  logic [bitWidth-1:0]   alu_result;

  // Iterative datapath state
  logic [2*bitWidth-1:0] acc_reg;
  logic [2*bitWidth-1:0] acc_step;
  logic [bitWidth-1:0]   opnd_reg;
  logic [SW-1:0]         cnt_reg;
  logic                  is_div_reg;
  logic                  hi_sel_reg;
  logic [bitWidth-1:0]   result_reg;
  logic [bitWidth:0]     mul_sum;
  logic [bitWidth:0]     div_diff;

  assign accept    = valid_i & ready_o;
  assign is_iter   = (op_i >= 4'd10) && (op_i <= 4'd13);
  assign last_step = (state_reg == BUSY) && (cnt_reg == SW'(bitWidth - 1));
  assign shamt     = rs2_i[SW-1:0];
  assign result_o  = result_reg;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; flush overrides both accept and consume
  always_comb begin
    state_next = state_reg;
    if (flush_i) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) state_next = is_iter ? BUSY : DONE;
        end
        BUSY: begin
          if (last_step) state_next = DONE;
        end
        DONE: begin
          if (ready_i) begin
            if (accept) state_next = is_iter ? BUSY : DONE;
            else        state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Handshake and status outputs decoded from the state
  always_comb begin
    ready_o = 1'b0;
    valid_o = (state_reg == DONE);
    busy_o  = (state_reg == BUSY);
    if (!flush_i) begin
      case (state_reg)
        IDLE:    ready_o = 1'b1;
        DONE:    ready_o = ready_i;
        default: ready_o = 1'b0;
      endcase
    end
  end

  // Single-cycle operations; codes 10-15 yield zero here
  always_comb begin
    case (op_i)
      4'd0:    alu_result = rs1_i + rs2_i;
      4'd1:    alu_result = rs1_i - rs2_i;
      4'd2:    alu_result = rs1_i & rs2_i;
      4'd3:    alu_result = rs1_i | rs2_i;
      4'd4:    alu_result = rs1_i ^ rs2_i;
      4'd5:    alu_result = {{(bitWidth-1){1'b0}}, ($signed(rs1_i) < $signed(rs2_i))};
      4'd6:    alu_result = {{(bitWidth-1){1'b0}}, (rs1_i < rs2_i)};
      4'd7:    alu_result = rs1_i << shamt;
      4'd8:    alu_result = rs1_i >> shamt;
      4'd9:    alu_result = $unsigned($signed(rs1_i) >>> shamt);
      default: alu_result = '0;
    endcase
  end

  // One radix-2 step: shift-add multiply, or restoring shift-subtract divide.
  // For divide the accumulator holds {remainder, quotient}; a borrow in
  // bit bitWidth of the trial difference means the divisor did not fit.
  always_comb begin
    mul_sum  = {1'b0, acc_reg[2*bitWidth-1:bitWidth]}
             + ({1'b0, opnd_reg} & {(bitWidth+1){acc_reg[0]}});
    div_diff = acc_reg[2*bitWidth-1:bitWidth-1] - {1'b0, opnd_reg};
    if (is_div_reg) begin
      if (div_diff[bitWidth]) acc_step = {acc_reg[2*bitWidth-2:0], 1'b0};
      else                    acc_step = {div_diff[bitWidth-1:0], acc_reg[bitWidth-2:0], 1'b1};
    end else begin
      acc_step = {mul_sum, acc_reg[bitWidth-1:1]};
    end
  end

  // Operand latch, iteration and result register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_reg    <= '0;
      opnd_reg   <= '0;
      cnt_reg    <= '0;
      is_div_reg <= 1'b0;
      hi_sel_reg <= 1'b0;
      result_reg <= '0;
    end else if (flush_i) begin
      acc_reg    <= '0;
      cnt_reg    <= '0;
      result_reg <= '0;
    end else if (accept) begin
      if (is_iter) begin
        // MUL/MULHU: multiplier rs2 shifts out of the low half.
        // DIVU/REMU: dividend rs1 shifts into the remainder half.
        is_div_reg <= op_i[2];
        hi_sel_reg <= op_i[0];
        opnd_reg   <= op_i[2] ? rs2_i : rs1_i;
        acc_reg    <= {{bitWidth{1'b0}}, (op_i[2] ? rs1_i : rs2_i)};
        cnt_reg    <= '0;
      end else begin
        result_reg <= alu_result;
      end
    end else if (state_reg == BUSY) begin
      acc_reg <= acc_step;
      cnt_reg <= cnt_reg + 1'b1;
      // High half is MULHU product or REMU remainder; low half is MUL or DIVU
      if (last_step) begin
        result_reg <= hi_sel_reg ? acc_step[2*bitWidth-1:bitWidth]
                                 : acc_step[bitWidth-1:0];
      end
    end
  end

endmodule

// File: tb/tb_arithm_seq.sv
// Directed bench for arithm_seq: one vector per operation with hand-computed
// results, plus stall, back-to-back, flush and reset-during-busy scenarios.
module tb_arithm_seq;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        valid_i = 1'b0;
  logic [3:0]  op_i = 4'd0;
  logic [31:0] rs1_i = '0;
  logic [31:0] rs2_i = '0;
  logic        ready_o;
  logic        flush_i = 1'b0;
  logic        valid_o;
  logic [31:0] result_o;
  logic        ready_i = 1'b1;
  logic        busy_o;

  int total = 0;
  int bad   = 0;

  arithm_seq #(.bitWidth(32)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .valid_i  (valid_i),
    .op_i     (op_i),
    .rs1_i    (rs1_i),
    .rs2_i    (rs2_i),
    .ready_o  (ready_o),
    .flush_i  (flush_i),
    .valid_o  (valid_o),
    .result_o (result_o),
    .ready_i  (ready_i),
    .busy_o   (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request, scramble inputs after accept, wait for valid_o and
  // check result, latency and busy duration. Consumer is always ready.
  task automatic run_op(input string tag, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat, input int exp_busy);
    int lat;
    int busy_cnt;
    @(negedge clk_i);
    ready_i = 1'b1;
    valid_i = 1'b1;
    op_i    = op;
    rs1_i   = a;
    rs2_i   = b;
    chk({tag, "_ready"}, {31'd0, ready_o}, 32'd1);
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    op_i    = 4'd0;
    rs1_i   = 32'hDEAD_BEEF;
    rs2_i   = 32'h1234_5678;
    lat      = 0;
    busy_cnt = 0;
    while (lat < 100) begin
      @(negedge clk_i);
      lat++;
      if (valid_o) break;
      if (busy_o) busy_cnt++;
    end
    chk({tag, "_valid"}, {31'd0, valid_o}, 32'd1);
    chk({tag, "_result"}, result_o, exp);
    chk({tag, "_lat"}, lat, exp_lat);
    if (exp_busy > 0) chk({tag, "_busy"}, busy_cnt, exp_busy);
    $display("txn %s op=%0d rs1=%h rs2=%h result=%h lat=%0d busy=%0d",
             tag, op, a, b, result_o, lat, busy_cnt);
  endtask

  initial begin
    int seen_valid;
    logic [31:0] held;

    // Reset state
    repeat (2) @(negedge clk_i);
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_result", result_o, 32'd0);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_ready_after", {31'd0, ready_o}, 32'd1);

    // Single-cycle operations
    run_op("add_wrap", 4'd0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1, 0);
    run_op("sub_wrap", 4'd1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1, 0);
    run_op("and",      4'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1, 0);
    run_op("or",       4'd3, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 1, 0);
    run_op("xor",      4'd4, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 1, 0);
    run_op("slt_neg",  4'd5, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 1, 0);
    run_op("sltu",     4'd6, 32'h8000_0000, 32'h0000_0001, 32'h0000_0000, 1, 0);
    run_op("slt_ovf",  4'd5, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1, 0);
    run_op("sra",      4'd9, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1, 0);
    run_op("srl",      4'd8, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000, 1, 0);
    run_op("sll",      4'd7, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 1, 0);
    run_op("illegal14", 4'd14, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 1, 0);
    run_op("illegal15", 4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1, 0);

    // Iterative operations
    run_op("mul_ones",   4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33, 32);
    run_op("mulhu_ones", 4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 32);
    run_op("mul_small",  4'd10, 32'd3, 32'd5, 32'd15, 33, 32);
    run_op("divu",       4'd12, 32'd100, 32'd7, 32'd14, 33, 32);
    run_op("remu",       4'd13, 32'd100, 32'd7, 32'd2, 33, 32);
    run_op("divu_zero",  4'd12, 32'd100, 32'd0, 32'hFFFF_FFFF, 33, 32);
    run_op("remu_zero",  4'd13, 32'd100, 32'd0, 32'd100, 33, 32);

    // Stall in DONE for 5 cycles, then back-to-back ADD on the consume cycle
    @(negedge clk_i);
    ready_i = 1'b0;
    valid_i = 1'b1;
    op_i = 4'd0; rs1_i = 32'd5; rs2_i = 32'd6;
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    @(negedge clk_i);
    chk("stall_valid0", {31'd0, valid_o}, 32'd1);
    chk("stall_result0", result_o, 32'd11);
    held = result_o;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk("stall_hold", result_o, 32'd11);
      chk("stall_ready_low", {31'd0, ready_o}, 32'd0);
    end
    $display("txn stall result=%h held=%h", result_o, held);
    ready_i = 1'b1;
    valid_i = 1'b1;
    op_i = 4'd0; rs1_i = 32'd1; rs2_i = 32'd2;
    #1;
    chk("b2b_ready", {31'd0, ready_o}, 32'd1);
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    @(negedge clk_i);
    chk("b2b_valid", {31'd0, valid_o}, 32'd1);
    chk("b2b_result", result_o, 32'd3);
    $display("txn b2b_add result=%h", result_o);
    @(negedge clk_i);
    chk("b2b_drained", {31'd0, valid_o}, 32'd0);

    // Flush at BUSY cycle 10
    valid_i = 1'b1;
    op_i = 4'd10; rs1_i = 32'd7; rs2_i = 32'd9;
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    repeat (10) @(negedge clk_i);
    chk("flush_busy_before", {31'd0, busy_o}, 32'd1);
    flush_i = 1'b1;
    #1;
    chk("flush_ready_low", {31'd0, ready_o}, 32'd0);
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
    seen_valid = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (valid_o) seen_valid++;
    end
    chk("flush_no_valid", seen_valid, 32'd0);
    chk("flush_idle_busy", {31'd0, busy_o}, 32'd0);
    chk("flush_idle_ready", {31'd0, ready_o}, 32'd1);
    $display("txn flush_mul valid_seen=%0d", seen_valid);

    // Asynchronous reset at BUSY cycle 10
    valid_i = 1'b1;
    op_i = 4'd12; rs1_i = 32'd1000; rs2_i = 32'd3;
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    repeat (10) @(negedge clk_i);
    chk("rstb_busy_before", {31'd0, busy_o}, 32'd1);
    #2;
    rst_i = 1'b1;
    #1;
    chk("rstb_async_busy", {31'd0, busy_o}, 32'd0);
    chk("rstb_async_result", result_o, 32'd0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("rstb_ready_after", {31'd0, ready_o}, 32'd1);
    seen_valid = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (valid_o) seen_valid++;
    end
    chk("rstb_no_valid", seen_valid, 32'd0);
    $display("txn reset_divu valid_seen=%0d", seen_valid);

    // Unit still works after reset
    run_op("post_rst_add", 4'd0, 32'd40, 32'd2, 32'd42, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
